// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce path: state encoding and
// the default filter length.
package key_pkg;

   typedef enum logic [1:0] {
      ST_UP      = 2'b00,
      ST_FILT_DN = 2'b01,
      ST_DOWN    = 2'b10,
      ST_FILT_UP = 2'b11
   } key_state_e;

   // 20 ms of stable level at a 50 MHz clock.
   localparam int unsigned DEBOUNCE_20MS_50MHZ = 1_000_000;

endpackage : key_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule : sync_2ff

// File: rtl/key_filter_edge.sv
// Debounces an active-low push-button and emits one-cycle press/release
// strobes plus a clean level (1 = released).
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_UP      | key accepted released, waiting for a low sample
//   ST_FILT_DN | key low, counting stable cycles before press
//   ST_DOWN    | key accepted pressed, waiting for a high sample
//   ST_FILT_UP | key high, counting stable cycles before release
module key_filter_edge
   import key_pkg::*;
#(
   parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_level,
   output logic neg_edge,
   output logic pos_edge
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   key_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             key_level_q;
   logic             neg_edge_q;
   logic             pos_edge_q;
   logic             key_s;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (key_in),
      .q_o   (key_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_UP;
         cnt_q       <= '0;
         key_level_q <= 1'b1;
         neg_edge_q  <= 1'b0;
         pos_edge_q  <= 1'b0;
      end else begin
         neg_edge_q <= 1'b0;
         pos_edge_q <= 1'b0;
         case (state_q)
            ST_UP: begin
               cnt_q <= '0;
               if (!key_s) state_q <= ST_FILT_DN;
            end
            ST_FILT_DN: begin
               if (key_s) begin
                  state_q <= ST_UP;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q     <= ST_DOWN;
                  cnt_q       <= '0;
                  neg_edge_q  <= 1'b1;
                  key_level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DOWN: begin
               cnt_q <= '0;
               if (key_s) state_q <= ST_FILT_UP;
            end
            ST_FILT_UP: begin
               if (!key_s) begin
                  state_q <= ST_DOWN;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q     <= ST_UP;
                  cnt_q       <= '0;
                  pos_edge_q  <= 1'b1;
                  key_level_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q     <= ST_UP;
               cnt_q       <= '0;
               key_level_q <= 1'b1;
            end
         endcase
      end
   end

   assign key_level = key_level_q;
   assign neg_edge  = neg_edge_q;
   assign pos_edge  = pos_edge_q;

endmodule : key_filter_edge

// File: tb/tb_key_filter_edge.sv
// Bench for key_filter_edge: directed scenarios plus random key activity,
// compared every cycle against a run-length model of the debounce rule.
module tb_key_filter_edge;

   localparam int unsigned DEB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_in = 1'b1;
   logic key_level, neg_edge, pos_edge;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_neg   = 0;
   int n_pos   = 0;
   int last_neg_cyc = -1;
   int last_pos_cyc = -1;

   key_filter_edge #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_level (key_level),
      .neg_edge  (neg_edge),
      .pos_edge  (pos_edge)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: the level flips once the synchronised key has disagreed with
   // it for DEB+1 consecutive samples (one to leave idle, DEB to count).
   logic m_s1, m_s2, m_level, m_neg, m_pos;
   int   m_run;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1;
         m_neg = 1'b0; m_pos = 1'b0; m_run = 0;
      end else begin
         logic ks;
         ks = m_s2;
         m_s2 = m_s1;
         m_s1 = key_in;
         m_neg = 1'b0;
         m_pos = 1'b0;
         if (ks != m_level) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
               m_level = ks;
               m_run = 0;
               if (ks) m_pos = 1'b1;
               else    m_neg = 1'b1;
            end
         end else begin
            m_run = 0;
         end
      end
   end

   always @(posedge clk) cyc++;

   logic prev_neg = 1'b0, prev_pos = 1'b0;
   always @(negedge clk) begin
      chk("level", key_level, m_level);
      chk("neg_edge", neg_edge, m_neg);
      chk("pos_edge", pos_edge, m_pos);
      chk("both_strobes", neg_edge & pos_edge, 1'b0);
      chk("neg_2wide", neg_edge & prev_neg, 1'b0);
      chk("pos_2wide", pos_edge & prev_pos, 1'b0);
      chk("cnt_range", 32'(dut.cnt_q) <= DEB - 1, 1'b1);
      if (neg_edge) begin n_neg++; last_neg_cyc = cyc; end
      if (pos_edge) begin n_pos++; last_pos_cyc = cyc; end
      prev_neg = neg_edge;
      prev_pos = pos_edge;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      int c, nn, np;
      wait_cyc(3);
      rst_n = 1'b1;

      // 1: idle high
      nn = n_neg; np = n_pos;
      wait_cyc(50);
      chk("t1_strobes", (n_neg - nn) + (n_pos - np), 0);
      chk("t1_level", key_level, 1'b1);

      // 2: press held
      nn = n_neg; c = cyc;
      key_in = 1'b0;
      wait_cyc(40);
      chk("t2_count", n_neg - nn, 1);
      chk("t2_latency", last_neg_cyc - c, 19);
      chk("t2_level", key_level, 1'b0);

      // 3: release held
      np = n_pos; c = cyc;
      key_in = 1'b1;
      wait_cyc(40);
      chk("t3_count", n_pos - np, 1);
      chk("t3_latency", last_pos_cyc - c, 19);
      chk("t3_level", key_level, 1'b1);

      // 4: short bounces never accepted
      nn = n_neg; np = n_pos;
      key_in = 1'b0; wait_cyc(10);
      key_in = 1'b1; wait_cyc(3);
      key_in = 1'b0; wait_cyc(10);
      key_in = 1'b1; wait_cyc(30);
      chk("t4_strobes", (n_neg - nn) + (n_pos - np), 0);
      chk("t4_level", key_level, 1'b1);

      // 5: bounce then settle low
      nn = n_neg;
      key_in = 1'b0; wait_cyc(5);
      key_in = 1'b1; wait_cyc(2);
      key_in = 1'b0; wait_cyc(7);
      key_in = 1'b1; wait_cyc(2);
      c = cyc;
      key_in = 1'b0; wait_cyc(30);
      chk("t5_count", n_neg - nn, 1);
      chk("t5_latency", last_neg_cyc - c, 19);
      key_in = 1'b1; wait_cyc(40);
      chk("t5_released", key_level, 1'b1);

      // 6: reset in the middle of the press filter
      nn = n_neg; np = n_pos;
      key_in = 1'b0;
      wait_cyc(11);
      chk("t6_cnt_mid", 32'(dut.cnt_q), 8);
      rst_n = 1'b0;
      wait_cyc(3);
      chk("t6_rst_strobes", (n_neg - nn) + (n_pos - np), 0);
      chk("t6_rst_level", key_level, 1'b1);
      c = cyc;
      rst_n = 1'b1;
      wait_cyc(30);
      chk("t6_count", n_neg - nn, 1);
      chk("t6_latency", last_neg_cyc - c, 19);
      key_in = 1'b1; wait_cyc(40);

      // random activity with occasional resets, checked by the model
      for (int i = 0; i < 400; i++) begin
         key_in = 1'($urandom_range(0, 1));
         wait_cyc(int'($urandom_range(1, 25)));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            wait_cyc(int'($urandom_range(1, 3)));
            rst_n = 1'b1;
         end
      end
      wait_cyc(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_key_filter_edge
